// File: rtl/we_top.sv
// -----------------------------------------------------------------------------
// we_top -- WearEChem SPI datapath wrapper
//
// Purpose:
//   On a trigger, a DATA_W-bit command word is loaded into an internal SPI
//   master and shifted out MSB first. MOSI is looped straight back into an
//   internal SPI slave shift register. When the frame ends, the received word
//   is pushed into a small output FIFO that the host drains with a read
//   enable. A single-cycle done_spi pulse marks each completed transfer.
//
// Ports:
//   clk                 in   system clock, all logic on rising edge
//   rst                 in   asynchronous active-low reset (0 = in reset)
//   data_in             in   word to transmit, sampled at transfer start
//   trigger_sys         in   start request, level-sampled while IDLE
//   rd_en_fifo_spi_out  in   FIFO read request
//   done_spi            out  one-cycle pulse per completed transfer
//   fifo_spi_out        out  registered FIFO read data
// -----------------------------------------------------------------------------
module we_top #(
  parameter int DATA_W     = 40,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              trigger_sys,
  input  logic              rd_en_fifo_spi_out,
  output logic              done_spi,
  output logic [DATA_W-1:0] fifo_spi_out
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    PUSH  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  // FSM outputs
  logic cs_n;
  logic load_en;
  logic shift_en;
  logic push_en;

  // SPI datapath
  logic [DATA_W-1:0] master_sr;
  logic [DATA_W-1:0] slave_sr;
  logic [CNT_W-1:0]  bit_cnt;
  logic              last_bit;
  logic              mosi;

  // FIFO
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              wr_fire;
  logic              rd_fire;

  assign last_bit = (bit_cnt == CNT_W'(DATA_W - 1));
  assign mosi     = master_sr[DATA_W-1];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (trigger_sys) state_next = LOAD;
      LOAD:    state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = PUSH;
      PUSH:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    cs_n     = 1'b1;
    load_en  = 1'b0;
    shift_en = 1'b0;
    push_en  = 1'b0;
    unique case (state)
      IDLE:  load_en = trigger_sys;
      LOAD:  cs_n = 1'b0;
      SHIFT: begin
        cs_n     = 1'b0;
        shift_en = 1'b1;
      end
      PUSH:  push_en = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // SPI master: parallel load at accept, then shift left MSB first
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      master_sr <= '0;
      bit_cnt   <= '0;
    end else if (load_en) begin
      master_sr <= data_in;
      bit_cnt   <= '0;
    end else if (shift_en) begin
      master_sr <= {master_sr[DATA_W-2:0], 1'b0};
      bit_cnt   <= bit_cnt + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // SPI slave: active while cs_n is low. The LOAD cycle (first cycle with
  // cs_n low) clears it so each frame starts from a clean register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slave_sr <= '0;
    end else if (!cs_n) begin
      if (state == LOAD) begin
        slave_sr <= '0;
      end else begin
        slave_sr <= {slave_sr[DATA_W-2:0], mosi};
      end
    end
  end

  // Completion pulse, registered so it is high for the cycle after PUSH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_spi <= 1'b0;
    end else begin
      done_spi <= push_en;
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO. Full/empty decisions use the occupancy before the edge, so a
  // write into a full FIFO is dropped even if a read happens on the same edge,
  // and a read of an empty FIFO ignores a write on the same edge.
  // ---------------------------------------------------------------------------
  assign full    = (count == OCC_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign wr_fire = push_en && !full;
  assign rd_fire = rd_en_fifo_spi_out && !empty;

  // Storage array kept reset-free so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr] <= slave_sr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      fifo_spi_out <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_fire) begin
        rd_ptr       <= rd_ptr + PTR_W'(1);
        fifo_spi_out <= mem[rd_ptr];
      end
      unique case ({wr_fire, rd_fire})
        2'b10:   count <= count + OCC_W'(1);
        2'b01:   count <= count - OCC_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_we_top.sv
// -----------------------------------------------------------------------------
// tb_we_top -- self-checking bench for we_top
//
// A transfer-level reference model (latency countdown plus a word queue)
// predicts done_spi and fifo_spi_out every cycle. Directed scenarios are
// followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_we_top;

  localparam int DATA_W     = 40;
  localparam int FIFO_DEPTH = 4;
  localparam int LAT        = DATA_W + 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] data_in = '0;
  logic              trigger_sys = 1'b0;
  logic              rd_en = 1'b0;
  logic              done_spi;
  logic [DATA_W-1:0] fifo_spi_out;

  always #5 clk = ~clk;

  we_top #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .data_in            (data_in),
    .trigger_sys        (trigger_sys),
    .rd_en_fifo_spi_out (rd_en),
    .done_spi           (done_spi),
    .fifo_spi_out       (fifo_spi_out)
  );

  int n_checks = 0;
  int n_errors = 0;
  int done_seen = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a transfer accepted at edge E0 completes LAT edges later,
  // where the word is queued (if room) and done is flagged for one cycle.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] m_out  = '0;
  logic [DATA_W-1:0] m_word = '0;
  logic              m_done = 1'b0;
  int                m_busy = 0;
  bit                m_full;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_out  = '0;
      m_done = 1'b0;
      m_busy = 0;
    end else begin
      m_done = 1'b0;
      m_full = (m_q.size() == FIFO_DEPTH);
      if (rd_en && m_q.size() > 0) begin
        m_out = m_q.pop_front();
      end
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_done = 1'b1;
          if (!m_full) m_q.push_back(m_word);
          $display("xfer word=%h %s", m_word, m_full ? "dropped" : "queued");
        end
      end else if (trigger_sys) begin
        m_word = data_in;
        m_busy = LAT;
      end
    end
  end

  // Drive inputs, wait one cycle, compare at the falling edge.
  task automatic step(input logic t, input logic r, input logic [DATA_W-1:0] d);
    trigger_sys = t;
    rd_en       = r;
    data_in     = d;
    @(negedge clk);
    check_val("done_spi", 64'(done_spi), 64'(m_done));
    check_val("fifo_spi_out", 64'(fifo_spi_out), 64'(m_out));
    if (done_spi) done_seen++;
  endtask

  function automatic logic [DATA_W-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DATA_W-1:0];
  endfunction

  localparam logic [DATA_W-1:0] WA = 40'h6e5f3a4d45;
  logic [DATA_W-1:0] words [5];

  initial begin
    words[0] = 40'h0102030405;
    words[1] = 40'hffeeddccbb;
    words[2] = 40'h8000000001;
    words[3] = 40'h5a5a5aa5a5;
    words[4] = 40'h123456789a;

    // Reset then idle
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("reset_done", 64'(done_spi), 64'(0));
    check_val("reset_out", 64'(fifo_spi_out), 64'(0));
    rst = 1'b1;
    repeat (5) step(1'b0, 1'b0, '0);
    check_val("idle_out", 64'(fifo_spi_out), 64'(0));

    // Single transfer
    done_seen = 0;
    step(1'b1, 1'b0, WA);
    repeat (LAT + 2) step(1'b0, 1'b0, '0);
    check_val("single_done_cnt", 64'(done_seen), 64'(1));
    step(1'b0, 1'b1, '0);
    check_val("single_rd", 64'(fifo_spi_out), 64'(WA));

    // Two triggers 52 cycles apart, then a long read burst
    done_seen = 0;
    step(1'b1, 1'b0, WA);
    repeat (51) step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, WA);
    repeat (LAT + 2) step(1'b0, 1'b0, '0);
    for (int k = 0; k < 50; k++) begin
      step(1'b0, 1'b1, '0);
      if (k < 2) check_val("two_rd", 64'(fifo_spi_out), 64'(WA));
    end
    check_val("two_hold", 64'(fifo_spi_out), 64'(WA));
    check_val("two_done_cnt", 64'(done_seen), 64'(2));

    // Trigger while busy is ignored
    done_seen = 0;
    step(1'b1, 1'b0, words[1]);
    repeat (9) step(1'b0, 1'b0, words[1]);
    step(1'b1, 1'b0, words[2]);
    repeat (45) step(1'b0, 1'b0, words[3]);
    check_val("busy_done_cnt", 64'(done_seen), 64'(1));
    step(1'b0, 1'b1, '0);
    check_val("busy_rd", 64'(fifo_spi_out), 64'(words[1]));
    step(1'b0, 1'b1, '0);
    check_val("busy_empty_hold", 64'(fifo_spi_out), 64'(words[1]));

    // Overfill: five transfers, fifth word dropped
    done_seen = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, words[i]);
      repeat (LAT) step(1'b0, 1'b0, '0);
    end
    check_val("full_done_cnt", 64'(done_seen), 64'(5));
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, '0);
      check_val("full_rd", 64'(fifo_spi_out), 64'(words[i]));
    end
    step(1'b0, 1'b1, '0);
    check_val("full_drop", 64'(fifo_spi_out), 64'(words[3]));

    // Reset mid-shift aborts the transfer
    done_seen = 0;
    step(1'b1, 1'b0, words[4]);
    repeat (20) step(1'b0, 1'b0, '0);
    rst = 1'b0;
    step(1'b0, 1'b0, '0);
    check_val("abort_out", 64'(fifo_spi_out), 64'(0));
    rst = 1'b1;
    repeat (50) step(1'b0, 1'b0, '0);
    check_val("abort_done_cnt", 64'(done_seen), 64'(0));
    step(1'b0, 1'b1, '0);
    check_val("abort_empty", 64'(fifo_spi_out), 64'(0));
    step(1'b1, 1'b0, words[2]);
    repeat (LAT) step(1'b0, 1'b0, '0);
    check_val("post_abort_done", 64'(done_seen), 64'(1));
    step(1'b0, 1'b1, '0);
    check_val("post_abort_rd", 64'(fifo_spi_out), 64'(words[2]));

    // Trigger held high: back-to-back re-triggering with random reads
    for (int i = 0; i < 300; i++) begin
      step(1'b1, ($urandom_range(0, 3) == 0), rand_word());
    end

    // Randomized traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        rst = 1'b0;
        step(1'b0, 1'b0, rand_word());
        rst = 1'b1;
      end else begin
        step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0), rand_word());
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/we_top.md
Name: we_top

Overview:
Top-level wrapper for the WearEChem SPI datapath.
- On a trigger, a 40-bit command word is serialised by an internal SPI master.
- The word travels over an internal loopback link (MOSI tied to the slave input) into an internal SPI slave shift register.
- The received word is pushed into an output FIFO, which the host drains through a read-enable.
- A single-cycle done_spi pulse marks each completed transfer.

Parameters:
DATA_W, 40, width of SPI word, FIFO word and data ports
FIFO_DEPTH, 4, output FIFO entries (power of two, >=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
data_in  input  DATA_W  word to transmit; sampled at transfer start
trigger_sys  input  1  start request, level-sampled while IDLE
rd_en_fifo_spi_out  input  1  FIFO read request
done_spi  output  1  one-cycle pulse per completed transfer
fifo_spi_out  output  DATA_W  registered FIFO read data

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - Shift registers, bit counter, FIFO pointers and count are cleared.
  - done_spi=0, fifo_spi_out=0.
  - Reset asserted mid-transfer aborts the transfer; nothing is written to the FIFO.
- FSM states: IDLE, LOAD, SHIFT, PUSH.
  - IDLE: at a rising edge with trigger_sys=1, latch data_in into the master shift register, clear the bit counter, go to LOAD.
  - LOAD: internal cs_n=0, slave shift register cleared. Go to SHIFT next edge.
  - SHIFT: on each edge, the master shifts left, MSB first. The bit leaving the master MSB enters the slave LSB (slave <= {slave[DATA_W-2:0], mosi}). Counter increments; after DATA_W shift edges go to PUSH.
  - PUSH: cs_n=1. Write slave word into FIFO if not full. Register done_spi=1 for exactly the next cycle. Return to IDLE.
- Latency:
  - A trigger sampled at edge E0 gives done_spi high during the cycle after edge E0+DATA_W+2, i.e. 42 edges for DATA_W=40.
  - The written word is readable from the next edge onward.
- Triggers:
  - trigger_sys while not IDLE is ignored; no queueing.
  - trigger_sys held high re-triggers on each return to IDLE.
- Loopback integrity: the received word equals the data_in sampled at E0, bit-exact.
- FIFO:
  - Synchronous, DATA_W x FIFO_DEPTH, wrap-around pointers, occupancy count 0..FIFO_DEPTH.
  - Write while full: the word is dropped and the count is unchanged; done_spi still pulses.
  - Read: when rd_en_fifo_spi_out=1 and not empty, fifo_spi_out <= head entry at the edge and the read pointer advances.
  - Read while empty has no effect; fifo_spi_out holds its last value.
  - Simultaneous read and write (non-empty, not full): both occur and the count is unchanged.
  - Simultaneous read and write when empty: only the write occurs; the data appears on a later read.
  - Ordering is strict FIFO.
- data_in changes after E0 do not affect the transfer in flight.

Test Plan:
- Reset then idle: rst=0 for 1 cycle, then rst=1; no trigger -> done_spi=0, fifo_spi_out=0 throughout.
- Single transfer: data_in=40'h6e5f3a4d45, trigger_sys pulsed 1 cycle -> done_spi single-cycle pulse 42 edges later. Then rd_en=1 for 1 cycle -> fifo_spi_out=40'h6e5f3a4d45.
- Two triggers ~52 cycles apart with rd_en=0, then rd_en held high for 50 cycles:
  - two done_spi pulses;
  - fifo_spi_out=40'h6e5f3a4d45 after the first read edge and again after the second;
  - fifo_spi_out holds 40'h6e5f3a4d45 once the FIFO is empty.
- Busy trigger: second trigger pulse 10 cycles after the first -> only one done_spi and one FIFO entry.
- Full FIFO: FIFO_DEPTH+1 transfers of words A,B,C,D,E without reads -> 5 done_spi pulses. Reads return A,B,C,D; E is dropped.
- Reset mid-SHIFT: rst=0 at cycle 20 of a transfer -> no done_spi, FIFO empty, next trigger completes normally.
